// File: rtl/rip_const.sv
// Shared core constants: lane geometry, RV32 load/store width encodings and LSU FSM states.
package rip_const;

    localparam int B_WIDTH   = 8;
    localparam int XLEN      = 32;
    localparam int NUM_LANES = XLEN / B_WIDTH;

    // Loads and stores share the low encodings, so stores reuse these values.
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_e;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/rip_lsu_align.sv
// Lane steering for the LSU: store replication/byte enables, load extraction/extension, error detect.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the outputs are used.
module rip_lsu_align
    import rip_const::*;
(
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [1:0]       req_addr_lo,
    input  logic [XLEN-1:0]  req_wdata,
    output logic [XLEN-1:0]  st_din,
    output logic [NUM_LANES-1:0] st_be,
    output logic             req_err,
    input  logic [2:0]       rd_funct3,
    input  logic [1:0]       rd_addr_lo,
    input  logic [XLEN-1:0]  rd_word,
    output logic [XLEN-1:0]  ld_data
);

    logic              illegal;
    logic              misaligned;
    logic [B_WIDTH-1:0]   byte_sel;
    logic [2*B_WIDTH-1:0] half_sel;

    always_comb begin
        st_din = req_wdata;
        st_be  = '0;
        case (req_funct3)
            F3_SB: begin
                st_din = {4{req_wdata[7:0]}};
                st_be  = 4'b0001 << req_addr_lo;
            end
            F3_SH: begin
                st_din = {2{req_wdata[15:0]}};
                st_be  = 4'b0011 << req_addr_lo;
            end
            F3_SW: begin
                st_din = req_wdata;
                st_be  = 4'b1111;
            end
            default: begin
                st_din = req_wdata;
                st_be  = '0;
            end
        endcase
    end

    always_comb begin
        illegal = 1'b0;
        if (req_we) begin
            illegal = (req_funct3 > F3_SW);
        end else begin
            case (req_funct3)
                3'b011, 3'b110, 3'b111: illegal = 1'b1;
                default:                illegal = 1'b0;
            endcase
        end
    end

    // Width lives in funct3[1:0] for both loads and stores.
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr_lo[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr_lo != 2'b00));
    assign req_err    = illegal || misaligned;

    assign byte_sel = rd_word[{rd_addr_lo, 3'b000} +: B_WIDTH];
    assign half_sel = rd_addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = '0;
        case (rd_funct3)
            F3_LB:   ld_data = {{(XLEN-B_WIDTH){byte_sel[B_WIDTH-1]}}, byte_sel};
            F3_LBU:  ld_data = {{(XLEN-B_WIDTH){1'b0}}, byte_sel};
            F3_LH:   ld_data = {{(XLEN-2*B_WIDTH){half_sel[2*B_WIDTH-1]}}, half_sel};
            F3_LHU:  ld_data = {{(XLEN-2*B_WIDTH){1'b0}}, half_sel};
            F3_LW:   ld_data = rd_word;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/rip_lsu_bram_master.sv
// Single-outstanding load/store initiator on BRAM port 1 with valid/ready request and response.
// Latency: store/error response one cycle after accept, load response two cycles after accept.
// Backpressure: rsp_ready low parks the FSM in RESP; no new request or BRAM access until taken.
module rip_lsu_bram_master
    import rip_const::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    mem_enable,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [3:0]              mem_we,
    output logic [DATA_WIDTH-1:0]   mem_din,
    input  logic [DATA_WIDTH-1:0]   mem_dout
);

    lsu_state_e      state;
    lsu_state_e      state_nxt;
    logic            accept;
    logic            req_err;
    logic [XLEN-1:0] st_din;
    logic [3:0]      st_be;
    logic [XLEN-1:0] ld_data;
    logic [2:0]      rd_funct3;
    logic [1:0]      rd_addr_lo;

    rip_lsu_align u_align (
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr_lo (req_addr[1:0]),
        .req_wdata   (req_wdata),
        .st_din      (st_din),
        .st_be       (st_be),
        .req_err     (req_err),
        .rd_funct3   (rd_funct3),
        .rd_addr_lo  (rd_addr_lo),
        .rd_word     (mem_dout),
        .ld_data     (ld_data)
    );

    assign req_ready  = (state == ST_IDLE) && rstn;
    assign accept     = req_valid && req_ready;
    assign rsp_valid  = (state == ST_RESP);

    // BRAM is only touched in the accept cycle, and never for a faulting request.
    assign mem_enable = accept && !req_err;
    assign mem_we     = (mem_enable && req_we) ? st_be : 4'b0000;
    assign mem_addr   = req_addr[ADDR_WIDTH+1:2];
    assign mem_din    = st_din;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (req_err || req_we) ? ST_RESP : ST_READ;
                end
            end
            ST_READ: state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            rd_funct3  <= '0;
            rd_addr_lo <= '0;
        end else if (accept) begin
            rsp_rdata  <= '0;
            rsp_err    <= req_err;
            rd_funct3  <= req_funct3;
            rd_addr_lo <= req_addr[1:0];
        end else if (state == ST_READ) begin
            rsp_rdata  <= ld_data;
        end
    end

endmodule

// File: tb/tb_rip_lsu_bram_master.sv
// Directed bench with a behavioural BRAM and a response scoreboard drained by a monitor.
module tb_rip_lsu_bram_master;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_enable;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          total;
    int          bad;
    logic [31:0] ram [1024];

    rip_lsu_bram_master #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_enable (mem_enable),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first BRAM with one-cycle registered read data.
    always @(posedge clk) begin
        if (mem_enable) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            end
            mem_dout <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rdata %h err %b expected no response", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rd);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                          input logic [3:0] exp_we, input logic [31:0] exp_din);
        int   lat;
        exp_t e;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'd1);
        chk("mem_enable", 32'(mem_enable), 32'(!exp_err));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        if (!exp_err) chk("mem_addr", 32'(mem_addr), 32'(addr[11:2]));
        if (we && !exp_err) chk("mem_din", mem_din, exp_din);
        e.rd  = exp_rd;
        e.err = exp_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (exp_err) chk("err_no_mem_enable", 32'(mem_enable), 32'd0);
            if (rsp_valid) break;
        end
        chk("latency", 32'(lat), (we || exp_err) ? 32'd1 : 32'd2);
        if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        mem_dout   = '0;
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_enable", 32'(mem_enable), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Word, byte and halfword stores with read-back
        do_req(1, 3'b010, 12'h010, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF);
        do_req(0, 3'b010, 12'h010, 32'h0, 32'hDEADBEEF, 0, 4'b0000, 32'h0);
        do_req(1, 3'b000, 12'h013, 32'h000000A5, 32'h0, 0, 4'b1000, 32'hA5A5A5A5);
        do_req(0, 3'b000, 12'h013, 32'h0, 32'hFFFFFFA5, 0, 4'b0000, 32'h0);
        do_req(0, 3'b100, 12'h013, 32'h0, 32'h000000A5, 0, 4'b0000, 32'h0);
        do_req(0, 3'b010, 12'h010, 32'h0, 32'hA5ADBEEF, 0, 4'b0000, 32'h0);
        do_req(1, 3'b001, 12'h022, 32'h00008001, 32'h0, 0, 4'b1100, 32'h80018001);
        do_req(0, 3'b001, 12'h022, 32'h0, 32'hFFFF8001, 0, 4'b0000, 32'h0);
        do_req(0, 3'b101, 12'h022, 32'h0, 32'h00008001, 0, 4'b0000, 32'h0);
        do_req(0, 3'b000, 12'h010, 32'h0, 32'hFFFFFFEF, 0, 4'b0000, 32'h0);
        do_req(0, 3'b100, 12'h011, 32'h0, 32'h000000BE, 0, 4'b0000, 32'h0);
        do_req(0, 3'b001, 12'h010, 32'h0, 32'hFFFFBEEF, 0, 4'b0000, 32'h0);

        // Misaligned and illegal encodings
        do_req(0, 3'b010, 12'h011, 32'h0, 32'h0, 1, 4'b0000, 32'h0);
        do_req(0, 3'b001, 12'h023, 32'h0, 32'h0, 1, 4'b0000, 32'h0);
        do_req(0, 3'b111, 12'h010, 32'h0, 32'h0, 1, 4'b0000, 32'h0);
        do_req(1, 3'b011, 12'h010, 32'h12345678, 32'h0, 1, 4'b0000, 32'h0);
        do_req(1, 3'b010, 12'h012, 32'h12345678, 32'h0, 1, 4'b0000, 32'h0);
        do_req(0, 3'b010, 12'h010, 32'h0, 32'hA5ADBEEF, 0, 4'b0000, 32'h0);

        // Top of address space
        do_req(1, 3'b010, 12'hFFC, 32'h12345678, 32'h0, 0, 4'b1111, 32'h12345678);
        do_req(0, 3'b010, 12'hFFC, 32'h0, 32'h12345678, 0, 4'b0000, 32'h0);

        // Backpressure on a load response
        rsp_ready = 1'b0;
        do_req(0, 3'b010, 12'h010, 32'h0, 32'hA5ADBEEF, 0, 4'b0000, 32'h0);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'hA5ADBEEF);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_mem_enable", 32'(mem_enable), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_last_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("bp_released", 32'(rsp_valid), 32'd0);
        chk("bp_req_ready_back", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset while the load sits in READ
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 12'h010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rr_req_ready", 32'(req_ready), 32'd0);
        chk("rr_rsp_rdata", rsp_rdata, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rr_hold_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("rr_req_ready_after", 32'(req_ready), 32'd1);
        chk("rr_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        do_req(0, 3'b010, 12'h010, 32'h0, 32'hA5ADBEEF, 0, 4'b0000, 32'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
